// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampled UART receiver with majority-vote sampling and parity/stop checking.
// Parity support (PARITY state, par_en/par_typ latches) is built only when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stop_err,
    output logic                  busy
);
    localparam int EW = $clog2(PRESCALE);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [EW-1:0] LAST  = EW'(PRESCALE - 1);
    localparam logic [EW-1:0] MID_M = EW'(PRESCALE / 2 - 1);
    localparam logic [EW-1:0] MID   = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] MID_P = EW'(PRESCALE / 2 + 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, next_state;
    logic                  rx_q, rx_s;
    logic [EW-1:0]         edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic                  s_a, s_b, sample_q, vote, sample, bit_end, start;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  perr, par_en_l, par_typ_l;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_q  <= 1'b1;
            rx_s  <= 1'b1;
            state <= IDLE;
        end else begin
            rx_q  <= rx_in;
            rx_s  <= rx_q;
            state <= next_state;
        end
    end

    // The vote is bypassed when M+1 coincides with the bit end (PRESCALE == 4).
    always_comb begin
        bit_end    = edge_cnt == LAST;
        vote       = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
        sample     = (edge_cnt == MID_P) ? vote : sample_q;
        next_state = state;
        case (state)
            IDLE:    next_state = rx_s ? IDLE : START;
            START:   next_state = !bit_end ? START : (sample ? IDLE : DATA);
            DATA:    next_state = (bit_end && bit_cnt == BLAST) ? (par_en_l ? PARITY : STOP) : DATA;
            PARITY:  next_state = bit_end ? STOP : PARITY;
            STOP:    next_state = !bit_end ? STOP : (rx_s ? IDLE : START);
            default: next_state = IDLE;
        endcase
        start = next_state == START && state != START;
        busy  = state != IDLE;
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_en_l  <= 1'b0;
            par_typ_l <= 1'b0;
        end else if (start) begin
            par_en_l  <= par_en;
            par_typ_l <= par_typ;
        end
    end
`else
    logic unused_par;
    assign par_en_l   = 1'b0;
    assign par_typ_l  = 1'b0;
    assign unused_par = par_en ^ par_typ;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            s_a        <= 1'b1;
            s_b        <= 1'b1;
            sample_q   <= 1'b1;
            shift_reg  <= '0;
            perr       <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stop_err   <= 1'b0;
            edge_cnt   <= (start || state == IDLE || bit_end) ? '0 : edge_cnt + 1'b1;
            if (edge_cnt == MID_M) s_a <= rx_s;
            if (edge_cnt == MID) s_b <= rx_s;
            if (edge_cnt == MID_P) sample_q <= vote;
            if (state == START) bit_cnt <= '0;
            else if (state == DATA && bit_end) bit_cnt <= bit_cnt + 1'b1;
            if (state == DATA && bit_end) shift_reg <= {sample, shift_reg[DATA_WIDTH-1:1]};
            if (start) perr <= 1'b0;
            else if (state == PARITY && bit_end) perr <= sample != (^shift_reg ^ par_typ_l);
            if (state == STOP && bit_end) begin
                par_err    <= perr;
                stop_err   <= !sample;
                data_valid <= !perr && sample;
                if (!perr && sample) p_data <= shift_reg;
            end
        end
    end
endmodule
